// File: rtl/lcd_read_nibbles.sv
// lcd_read_nibbles
//   Read-side controller for a 4-bit character LCD. Raises R/W, strobes E
//   twice, samples the panel's upper then lower nibble and reassembles one
//   byte: either the busy flag/address counter (RS=0) or display RAM data
//   (RS=1). The pad tri-state is controlled externally from lcdRW.
//
// Parameters
//   T_SETUP  cycles RS/RW are stable before E rises (1..255)
//   T_EHIGH  cycles E is held high per nibble (1..255)
//   T_GAP    cycles E is held low after each nibble (1..255)
//
// Ports
//   CLK        in   system clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   doRead     in   start request, sampled only while idle
//   readRS     in   register select for the read, latched at start
//   lcdDataIn  in   DB7..DB4 from the panel
//   lcdRS      out  LCD register select
//   lcdRW      out  LCD read/write (1 = read), also pad tri-state control
//   lcdEnable  out  LCD E strobe
//   busy       out  high whenever a transfer is in progress
//   dataValid  out  one-cycle pulse when dataOut is updated
//   dataOut    out  last assembled byte {upper, lower}
//   busyFlag   out  bit 7 of the last RS=0 read
module lcd_read_nibbles #(
  parameter int T_SETUP = 2,
  parameter int T_EHIGH = 12,
  parameter int T_GAP   = 50
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       doRead,
  input  logic       readRS,
  input  logic [3:0] lcdDataIn,
  output logic       lcdRS,
  output logic       lcdRW,
  output logic       lcdEnable,
  output logic       busy,
  output logic       dataValid,
  output logic [7:0] dataOut,
  output logic       busyFlag
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_PULSE_HI = 3'd2,
    S_GAP_HI   = 3'd3,
    S_PULSE_LO = 3'd4,
    S_GAP_LO   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  // Counter reload values: each timed state lasts N cycles, so the counter
  // starts at N-1 and the state ends on the cycle it reads zero.
  localparam logic [7:0] SETUP_LOAD = 8'(T_SETUP - 1);
  localparam logic [7:0] EHIGH_LOAD = 8'(T_EHIGH - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(T_GAP - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_count;
  logic [7:0] w_loadValue;
  logic       w_countDone;
  logic       r_rsReg;
  logic [3:0] r_hi;
  logic [3:0] r_lo;
  logic [7:0] r_dataOut;
  logic       r_busyFlag;

  assign w_countDone = (r_count == 8'd0);

  // Next-state logic. Requests are only looked at in IDLE, so anything
  // arriving mid-transfer is simply dropped. DONE always lasts one cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:     if (doRead)      w_nextState = S_SETUP;
      S_SETUP:    if (w_countDone) w_nextState = S_PULSE_HI;
      S_PULSE_HI: if (w_countDone) w_nextState = S_GAP_HI;
      S_GAP_HI:   if (w_countDone) w_nextState = S_PULSE_LO;
      S_PULSE_LO: if (w_countDone) w_nextState = S_GAP_LO;
      S_GAP_LO:   if (w_countDone) w_nextState = S_DONE;
      S_DONE:                      w_nextState = S_IDLE;
      default:                     w_nextState = S_IDLE;
    endcase
  end

  // Duration to load when entering a state; untimed states load zero.
  always_comb begin
    w_loadValue = 8'd0;
    case (w_nextState)
      S_SETUP:    w_loadValue = SETUP_LOAD;
      S_PULSE_HI: w_loadValue = EHIGH_LOAD;
      S_GAP_HI:   w_loadValue = GAP_LOAD;
      S_PULSE_LO: w_loadValue = EHIGH_LOAD;
      S_GAP_LO:   w_loadValue = GAP_LOAD;
      default:    w_loadValue = 8'd0;
    endcase
  end

  // State register and cycle counter. The counter reloads whenever the
  // state changes and otherwise counts down to zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_count <= 8'd0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state) begin
        r_count <= w_loadValue;
      end else if (!w_countDone) begin
        r_count <= r_count - 8'd1;
      end
    end
  end

  // Datapath: RS latch at start, nibble capture on the edge that ends each
  // E pulse, and the result registers updated on the edge entering DONE so
  // the new byte is visible exactly while dataValid is high. Reset clears
  // the partial nibbles so an aborted transfer leaves nothing behind.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rsReg    <= 1'b0;
      r_hi       <= 4'h0;
      r_lo       <= 4'h0;
      r_dataOut  <= 8'h00;
      r_busyFlag <= 1'b0;
    end else begin
      if (r_state == S_IDLE && doRead) begin
        r_rsReg <= readRS;
      end
      if (r_state == S_PULSE_HI && w_countDone) begin
        r_hi <= lcdDataIn;
      end
      if (r_state == S_PULSE_LO && w_countDone) begin
        r_lo <= lcdDataIn;
      end
      if (r_state == S_GAP_LO && w_countDone) begin
        r_dataOut <= {r_hi, r_lo};
        if (!r_rsReg) begin
          r_busyFlag <= r_hi[3];
        end
      end
    end
  end

  // Output decode from registered state only; no input reaches an output
  // combinationally.
  always_comb begin
    lcdRW     = 1'b0;
    lcdEnable = 1'b0;
    dataValid = 1'b0;
    case (r_state)
      S_SETUP, S_GAP_HI, S_GAP_LO: lcdRW = 1'b1;
      S_PULSE_HI, S_PULSE_LO: begin
        lcdRW     = 1'b1;
        lcdEnable = 1'b1;
      end
      S_DONE: begin
        lcdRW     = 1'b1;
        dataValid = 1'b1;
      end
      default: ;
    endcase
  end

  assign lcdRS    = lcdRW & r_rsReg;
  assign busy     = (r_state != S_IDLE);
  assign dataOut  = r_dataOut;
  assign busyFlag = r_busyFlag;

endmodule
